data_mem_mmio: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/data_mem_mmio_timer.sv | 80 ++++++++
 rtl/data_mem_mmio.sv | 83 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory / MMIO stage: register addresses,
// TCTRL bit positions and the timer state encoding.
package dmem_pkg;

   localparam logic [31:0] GPIO_ADDR  = 32'hFFFF_0000;
   localparam logic [31:0] TCNT_ADDR  = 32'hFFFF_0004;
   localparam logic [31:0] TCMP_ADDR  = 32'hFFFF_0008;
   localparam logic [31:0] TCTRL_ADDR = 32'hFFFF_000C;

   localparam int unsigned EN_BIT   = 0;
   localparam int unsigned AR_BIT   = 1;
   localparam int unsigned PEND_BIT = 2;

   typedef enum logic {T_IDLE, T_RUN} tstate_t;

   // Word-granular address compare; byte offset bits are ignored.
   function automatic logic addr_hit(input logic [31:0] a, input logic [31:0] base);
      return a[31:2] == base[31:2];
   endfunction

endpackage

// File: rtl/data_mem_mmio_timer.sv
// Memory-mapped compare timer: counter, compare, control/pending and the
// run/idle FSM. Instantiated by data_mem_mmio when DMEM_MMIO_TIMER_EN is set.
module mmio_timer
   import dmem_pkg::*;
#(
   parameter int unsigned TIMER_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_tcmp,
   input  logic        we_tctrl,
   input  logic [31:0] wdata,
   output logic [31:0] tcnt_rd,
   output logic [31:0] tcmp_rd,
   output logic [31:0] tctrl_rd,
   output logic        irq
);

   tstate_t            state;
   logic [TIMER_W-1:0] tcnt;
   logic [TIMER_W-1:0] tcmp;
   logic               ar;
   logic               pending;
   logic               stop_req;

   assign stop_req = we_tctrl && !wdata[EN_BIT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= T_IDLE;
         tcnt    <= '0;
         tcmp    <= '1;
         ar      <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (we_tcmp)
            tcmp <= wdata[TIMER_W-1:0];
         if (we_tctrl) begin
            ar <= wdata[AR_BIT];
            if (wdata[PEND_BIT])
               pending <= 1'b0;
         end
         case (state)
            T_IDLE: begin
               if (we_tctrl && wdata[EN_BIT]) begin
                  tcnt  <= '0;
                  state <= T_RUN;
               end
            end
            T_RUN: begin
               // A match sets pending after the clear above, so the set wins.
               if (tcnt == tcmp) begin
                  pending <= 1'b1;
                  if (ar && !stop_req)
                     tcnt <= '0;
                  else
                     state <= T_IDLE;
               end else if (stop_req) begin
                  state <= T_IDLE;
               end else begin
                  tcnt <= tcnt + TIMER_W'(1);
               end
            end
            default: state <= T_IDLE;
         endcase
      end
   end

   always_comb begin
      tcnt_rd  = 32'(tcnt);
      tcmp_rd  = 32'(tcmp);
      tctrl_rd = '0;
      tctrl_rd[EN_BIT]   = (state == T_RUN);
      tctrl_rd[AR_BIT]   = ar;
      tctrl_rd[PEND_BIT] = pending;
   end

   assign irq = pending;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM, GPIO register and (with DMEM_MMIO_TIMER_EN
// defined) a compare timer; combinational loads, stores on the rising edge.
module data_mem_mmio
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned TIMER_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic [31:0] gpio_out,
   output logic        timer_irq
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          is_ram;
   logic          is_gpio;
   logic          unused_ok;

   assign idx       = addr[AW+1:2];
   assign is_ram    = (addr[31:AW+2] == '0);
   assign is_gpio   = addr_hit(addr, GPIO_ADDR);
   assign unused_ok = ^addr[1:0];

   // RAM has no reset; a store coinciding with reset is still dropped.
   always_ff @(posedge clk) begin
      if (!reset && mem_write && is_ram)
         mem[idx] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)
         gpio_out <= '0;
      else if (mem_write && is_gpio)
         gpio_out <= wdata;
   end

`ifdef DMEM_MMIO_TIMER_EN
   logic        is_tcnt, is_tcmp, is_tctrl;
   logic [31:0] tcnt_rd, tcmp_rd, tctrl_rd;

   assign is_tcnt  = addr_hit(addr, TCNT_ADDR);
   assign is_tcmp  = addr_hit(addr, TCMP_ADDR);
   assign is_tctrl = addr_hit(addr, TCTRL_ADDR);

   mmio_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .we_tcmp  (mem_write && is_tcmp),
      .we_tctrl (mem_write && is_tctrl),
      .wdata    (wdata),
      .tcnt_rd  (tcnt_rd),
      .tcmp_rd  (tcmp_rd),
      .tctrl_rd (tctrl_rd),
      .irq      (timer_irq)
   );

   always_comb begin
      rdata = '0;
      if (is_ram)        rdata = mem[idx];
      else if (is_gpio)  rdata = gpio_out;
      else if (is_tcnt)  rdata = tcnt_rd;
      else if (is_tcmp)  rdata = tcmp_rd;
      else if (is_tctrl) rdata = tctrl_rd;
   end
`else
   assign timer_irq = 1'b0;

   always_comb begin
      rdata = '0;
      if (is_ram)       rdata = mem[idx];
      else if (is_gpio) rdata = gpio_out;
   end
`endif

endmodule
